sram_responder: RTL and testbench
=================================

# sram_responder

Slave-side responder terminating one slave port of the SoRIC data interconnect on a single-port synchronous SRAM macro. It accepts req/gnt requests routed by the interconnect and drives the macro's chip-select, write-enable and write-mask pins. It returns exactly one in-order rvalid response per granted request at a fixed latency. After reset it optionally zero-fills the macro before granting any request.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; BE_WIDTH = DATA_WIDTH/8
- ADDR_WIDTH, 10, byte address width on the bus side (interconnect SLAVE_ADDR_WIDTH)
- WORDS, 256, implemented SRAM words; word index = addr_i[ADDR_WIDTH-1:$clog2(BE_WIDTH)]
- SRAM_LATENCY, 1, rising edges from macro sampling a read to sram_dout_i valid; legal 1..3
- INIT_ZERO, 1, 1 = zero-fill the macro after reset

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_i  input  1  request
- addr_i  input  ADDR_WIDTH  byte address
- we_i  input  1  1 = write
- be_i  input  BE_WIDTH  byte enables
- wdata_i  input  DATA_WIDTH  write data
- gnt_o  output  1  request accepted this cycle
- rvalid_o  output  1  response valid, one-cycle pulse per response
- rdata_o  output  DATA_WIDTH  read data
- err_o  output  1  qualifies rvalid_o; out-of-range address
- init_done_o  output  1  zero-fill complete
- sram_csb_o  output  1  macro chip select, active-low
- sram_web_o  output  1  macro write enable, active-low
- sram_wmask_o  output  BE_WIDTH  macro byte write mask
- sram_addr_o  output  $clog2(WORDS)  macro word address
- sram_din_o  output  DATA_WIDTH  macro write data
- sram_dout_i  input  DATA_WIDTH  macro read data

## Operation
- FSM states INIT and RUN. Reset enters INIT when INIT_ZERO = 1, otherwise RUN.
- INIT:
  - gnt_o = 0, csb = 0, web = 0, wmask all ones, din = 0.
  - sram_addr_o is driven from an init counter that runs 0..WORDS-1, one word per cycle.
  - The cycle after word WORDS-1 is written, the FSM enters RUN and init_done_o rises.
  - init_done_o stays 1 until the next reset; it is 1 immediately out of reset when INIT_ZERO = 0.
- RUN: gnt_o = req_i, combinational. There are no wait states, so one request is accepted per cycle.
- Accepted request with word index < WORDS:
  - csb = 0, web = ~we_i, wmask = we_i ? be_i : 0, addr = index, din = wdata_i, all in the same cycle.
- Accepted request with word index >= WORDS:
  - No macro access (csb = 1).
  - The response carries err_o = 1 and rdata_o = 0.
- Writes, including be_i = 0, also receive exactly one response: rvalid_o = 1, err_o = 0, rdata_o unchanged.
- Reads: rdata_o is loaded with sram_dout_i and holds that value until the next read or error response.
- Responses are returned in acceptance order. Request fields are ignored when gnt_o = 0.
- Whenever no access is issued, csb = 1 and web = 1.

## Timing
- A request accepted in cycle T gets its response (rvalid_o and the qualified rdata_o/err_o) in cycle T+SRAM_LATENCY+1.
  - sram_dout_i is sampled at the end of cycle T+SRAM_LATENCY.
  - rvalid_o, rdata_o and err_o are registered outputs.
- Back-to-back requests produce back-to-back rvalid pulses. A read immediately after a write to the same word returns the new data.
- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, init_done_o 0 (1 if INIT_ZERO = 0), sram_csb_o 1, sram_web_o 1, wmask 0, addr 0, din 0.
- Reset mid-operation, asserted asynchronously:
  - The response pipeline is flushed and in-flight responses are never issued.
  - The init counter clears and the FSM returns to its reset state.
- The first grant occurs no earlier than WORDS cycles after reset release when INIT_ZERO = 1.

## Structure
- Shared package/header `soric_mem_pkg`: FSM state encodings (ST_INIT, ST_RUN) and the SRAM_LATENCY legal range check.
- Sub-module `mem_resp_pipe`: shift register of depth SRAM_LATENCY+1 carrying {valid, is_read, err}, plus the rdata capture register. Same clk/reset.
- The top holds the FSM, init counter, range check and macro pin muxing.

## Test plan
- Reset release with WORDS = 256, INIT_ZERO = 1 → 256 cycles of csb = 0/web = 0 at addresses 0..255 with din 0. gnt_o is held 0 throughout. init_done_o rises at cycle 256.
- Write 0xDEADBEEF at byte addr 0x010 with be 0xF, then read 0x010 on the next cycle → two consecutive rvalid pulses at T+2 and T+3 (SRAM_LATENCY = 1). The read returns 0xDEADBEEF with err_o 0.
- Write be = 0x3 with data 0xAAAA5555 over a word holding 0x12345678, then read → 0x12345555.
- Read of word index 300 (addr 0x4B0) with WORDS = 256 → csb stays 1. The response at T+2 has err_o 1 and rdata_o 0.
- Continuous reads of addresses 0..15 with SRAM_LATENCY = 3 → 16 consecutive rvalid pulses starting at T+4, data in order.
- Reset asserted with 2 reads in flight → no rvalid_o after reset, outputs at reset values, and INIT restarts from address 0.

Source files
------------

// File: rtl/soric_mem_pkg.sv
// Shared definitions for the SoRIC SRAM slave-side responder.
package soric_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SRAM_LAT_MIN = 1;
    localparam int SRAM_LAT_MAX = 3;

    function automatic bit sram_latency_legal(input int lat);
        return (lat >= SRAM_LAT_MIN) && (lat <= SRAM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Response pipeline: tracks each accepted request until the macro data is
// valid, then registers rvalid/err/rdata as one in-order response.
module mem_resp_pipe
    import soric_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic                  i_is_read,
    input  logic                  i_err,
    input  logic [DATA_WIDTH-1:0] i_sram_dout,
    output logic                  o_rvalid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int LAST = SRAM_LATENCY - 1;

    logic [SRAM_LATENCY-1:0] r_valid;
    logic [SRAM_LATENCY-1:0] r_read;
    logic [SRAM_LATENCY-1:0] r_err;
    logic                    r_rvalid;
    logic                    r_rerr;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_tail_valid;
    logic                    w_tail_read;
    logic                    w_tail_err;

    assign w_tail_valid = r_valid[LAST];
    assign w_tail_read  = r_read[LAST];
    assign w_tail_err   = r_err[LAST];

    // Delay line of request attributes, one stage per macro latency cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_read  <= '0;
            r_err   <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_read[0]  <= i_valid & i_is_read;
            r_err[0]   <= i_valid & i_err;
            for (int k = 1; k < SRAM_LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_read[k]  <= r_read[k-1];
                r_err[k]   <= r_err[k-1];
            end
        end
    end

    // Final response stage; rdata holds across write responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_tail_valid;
            r_rerr   <= w_tail_valid & w_tail_err;
            if (w_tail_valid && w_tail_err) begin
                r_rdata <= '0;
            end else if (w_tail_valid && w_tail_read) begin
                r_rdata <= i_sram_dout;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_err    = r_rerr;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// Terminates one interconnect slave port on a single-port synchronous SRAM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | zero-filling the macro one word per cycle, no grants
// ST_RUN  | grant every request, drive macro pins combinationally
module sram_responder
    import soric_mem_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 10,
    parameter  int WORDS        = 256,
    parameter  int SRAM_LATENCY = 1,
    parameter  int INIT_ZERO    = 1,
    localparam int BE_WIDTH     = DATA_WIDTH / 8,
    localparam int WADDR_W      = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  init_done_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [BE_WIDTH-1:0]   sram_wmask_o,
    output logic [WADDR_W-1:0]    sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    localparam int           OFF      = $clog2(BE_WIDTH);
    localparam int           IDX_W    = ADDR_WIDTH - OFF;
    localparam state_t       ST_RESET = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    localparam [WADDR_W-1:0] LAST_W   = WADDR_W'(WORDS - 1);

    generate
        if (!sram_latency_legal(SRAM_LATENCY)) begin : g_bad_latency
            $error("sram_responder: SRAM_LATENCY out of range 1..3");
        end
        if (OFF > 0) begin : g_lsb
            logic w_unused_addr_lsb;
            assign w_unused_addr_lsb = ^addr_i[OFF-1:0];
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WADDR_W-1:0]  r_init_cnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_in_range;
    logic                w_gnt;
    logic                w_csb;
    logic                w_web;
    logic [BE_WIDTH-1:0] w_wmask;
    logic [WADDR_W-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic                w_acc_valid;
    logic                w_acc_read;
    logic                w_acc_err;

    assign w_idx      = addr_i[ADDR_WIDTH-1:OFF];
    assign w_in_range = (32'(w_idx) < 32'(WORDS));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Zero-fill word pointer, advances only while filling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + WADDR_W'(1);
        end
    end

    // Next state, grant and macro pin muxing; pins idle while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_csb       = 1'b1;
        w_web       = 1'b1;
        w_wmask     = '0;
        w_addr      = '0;
        w_din       = '0;
        w_acc_valid = 1'b0;
        w_acc_read  = 1'b0;
        w_acc_err   = 1'b0;
        if (reset) begin
            case (r_state)
                ST_INIT: begin
                    w_csb   = 1'b0;
                    w_web   = 1'b0;
                    w_wmask = '1;
                    w_addr  = r_init_cnt;
                    if (r_init_cnt == LAST_W) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_gnt = req_i;
                    if (req_i) begin
                        w_acc_valid = 1'b1;
                        w_acc_read  = ~we_i;
                        w_acc_err   = ~w_in_range;
                        if (w_in_range) begin
                            w_csb   = 1'b0;
                            w_web   = ~we_i;
                            w_wmask = we_i ? be_i : '0;
                            w_addr  = WADDR_W'(w_idx);
                            w_din   = wdata_i;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_o        = w_gnt;
    assign init_done_o  = (r_state == ST_RUN);
    assign sram_csb_o   = w_csb;
    assign sram_web_o   = w_web;
    assign sram_wmask_o = w_wmask;
    assign sram_addr_o  = w_addr;
    assign sram_din_o   = w_din;

    mem_resp_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SRAM_LATENCY (SRAM_LATENCY)
    ) u_resp_pipe (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (w_acc_valid),
        .i_is_read   (w_acc_read),
        .i_err       (w_acc_err),
        .i_sram_dout (sram_dout_i),
        .o_rvalid    (rvalid_o),
        .o_err       (err_o),
        .o_rdata     (rdata_o)
    );

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (macro latency 1 and 3) share the
// same stimulus; each has its own behavioural macro and response queue.
module tb_sram_responder;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int WORDS = 256;
    localparam int NI    = 2;

    typedef struct {
        int          cyc;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;

    logic        gnt[NI], rvalid[NI], err[NI], idone[NI], csb[NI], web[NI];
    logic [31:0] rdata[NI], din[NI], dout[NI];
    logic [3:0]  wmask[NI];
    logic [7:0]  saddr[NI];

    logic [31:0] mem[NI][WORDS];
    logic [31:0] dpipe[NI][3];
    logic [31:0] ref_mem[WORDS];
    logic [31:0] last_rd[NI];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS(WORDS),
                     .SRAM_LATENCY(1), .INIT_ZERO(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]), .init_done_o(idone[0]),
        .sram_csb_o(csb[0]), .sram_web_o(web[0]), .sram_wmask_o(wmask[0]),
        .sram_addr_o(saddr[0]), .sram_din_o(din[0]), .sram_dout_i(dout[0]));

    sram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS(WORDS),
                     .SRAM_LATENCY(3), .INIT_ZERO(1)) u_dut_l3 (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]), .init_done_o(idone[1]),
        .sram_csb_o(csb[1]), .sram_web_o(web[1]), .sram_wmask_o(wmask[1]),
        .sram_addr_o(saddr[1]), .sram_din_o(din[1]), .sram_dout_i(dout[1]));

    assign dout[0] = dpipe[0][0];
    assign dout[1] = dpipe[1][2];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port macros with read latency set by dpipe depth.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!csb[i] && !web[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[i][b]) mem[i][saddr[i]][8*b +: 8] <= din[i][8*b +: 8];
                end
            end
            dpipe[i][0] <= (!csb[i] && web[i]) ? mem[i][saddr[i]] : 32'h0;
            dpipe[i][1] <= dpipe[i][0];
            dpipe[i][2] <= dpipe[i][1];
        end
    end

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic resp_check(input int i);
        exp_t        x;
        int          lat;
        logic [31:0] ed;
        lat = (i == 0) ? 1 : 3;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk_val($sformatf("unexpected_rvalid%0d", i), 64'(rvalid[i]), 64'd0);
            return;
        end
        if (i == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        if (x.err)     ed = 32'h0;
        else if (x.rd) ed = x.data;
        else           ed = last_rd[i];
        last_rd[i] = ed;
        chk_val($sformatf("resp_cycle%0d", i), 64'(cyc), 64'(x.cyc + lat + 1));
        chk_val($sformatf("resp_err%0d", i), 64'(err[i]), 64'(x.err));
        chk_val($sformatf("resp_rdata%0d", i), 64'(rdata[i]), 64'(ed));
    endtask

    // Response monitor: every rvalid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < NI; i++) begin
                if (rvalid[i] === 1'b1) resp_check(i);
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [3:0] bev,
                         input logic [31:0] d);
        exp_t x;
        int   idx;
        logic inr;
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; be = bev; wdata = d;
        idx = int'(a[AW-1:2]);
        inr = (idx < WORDS);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk_val($sformatf("gnt%0d", i), 64'(gnt[i]), 64'd1);
            if (inr)
                chk_val($sformatf("pins%0d", i), 64'({csb[i], web[i], wmask[i], saddr[i], din[i]}),
                        64'({1'b0, ~w, (w ? bev : 4'h0), 8'(idx), d}));
            else
                chk_val($sformatf("csb_oor%0d", i), 64'({csb[i], web[i]}), 64'(2'b11));
        end
        x.cyc  = cyc;
        x.err  = !inr;
        x.rd   = !w;
        x.data = inr ? ref_mem[idx] : 32'h0;
        if (inr && w) begin
            for (int b = 0; b < 4; b++) begin
                if (bev[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        q0.push_back(x);
        q1.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = 1'b0; we = 1'($urandom_range(0, 1)); addr = AW'($urandom());
            be = 4'($urandom_range(0, 15)); wdata = $urandom();
            #1;
            for (int i = 0; i < NI; i++)
                chk_val($sformatf("idle_pins%0d", i), 64'({gnt[i], csb[i], web[i]}), 64'(3'b011));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk_val($sformatf("%s_ctl%0d", tag, i),
                    64'({gnt[i], rvalid[i], err[i], idone[i], csb[i], web[i], wmask[i], saddr[i]}),
                    64'({4'b0000, 2'b11, 4'h0, 8'h00}));
            chk_val($sformatf("%s_din%0d", tag, i), 64'(din[i]), 64'd0);
            chk_val($sformatf("%s_rdata%0d", tag, i), 64'(rdata[i]), 64'd0);
        end
    endtask

    task automatic chk_init(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                chk_val($sformatf("%s_c%0d_%0d", tag, c, i),
                        64'({gnt[i], rvalid[i], csb[i], web[i], wmask[i], saddr[i], din[i], idone[i]}),
                        64'({3'b000, 1'b0, 4'hF, 8'(c), 32'h0, 1'b0}));
        end
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        for (int k = 0; k < WORDS; k++) ref_mem[k] = 32'h0;
        for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;

        // Requests pending during reset and INIT must never be granted.
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 12'h010; be = 4'hF; wdata = 32'hFFFF_FFFF;
        #1;
        chk_reset_vals("reset0");
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk_init("init", WORDS);
        req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk_val($sformatf("init_done%0d", i), 64'({idone[i], csb[i]}), 64'(2'b11));

        // Write then read same word, back to back.
        issue(1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 12'h010, 4'hF, 32'h0);
        idle(2);
        // Partial write over an existing word, then a zero-mask write.
        issue(1'b1, 12'h020, 4'hF, 32'h1234_5678);
        issue(1'b1, 12'h020, 4'h3, 32'hAAAA_5555);
        issue(1'b0, 12'h020, 4'h0, 32'h0);
        issue(1'b1, 12'h020, 4'h0, 32'hFFFF_FFFF);
        issue(1'b0, 12'h020, 4'hF, 32'h0);
        idle(1);
        // Range boundaries: word 300, word 256 (first illegal), word 255 (last legal).
        issue(1'b0, 12'h4B0, 4'hF, 32'h0);
        issue(1'b1, 12'h400, 4'hF, 32'h5A5A_5A5A);
        issue(1'b1, 12'h3FC, 4'hF, 32'hCAFE_F00D);
        issue(1'b0, 12'h3FC, 4'hF, 32'h0);
        idle(2);
        // Fill words 0..15 then stream them back with no gaps.
        for (int k = 0; k < 16; k++) issue(1'b1, AW'(k * 4), 4'hF, 32'h1000_0000 + 32'(k * 32'h0101));
        for (int k = 0; k < 16; k++) issue(1'b0, AW'(k * 4), 4'hF, 32'h0);
        idle(3);
        // Mixed random traffic with random gaps and occasional out-of-range hits.
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 6) == 0) a = AW'(12'h800 + 4 * $urandom_range(0, 100));
            else                          a = AW'(4 * $urandom_range(0, 19));
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
        end
        idle(8);
        chk_val("drain_l1", 64'(q0.size()), 64'd0);
        chk_val("drain_l3", 64'(q1.size()), 64'd0);

        // Asynchronous reset with reads still in flight.
        issue(1'b0, 12'h010, 4'hF, 32'h0);
        issue(1'b0, 12'h014, 4'hF, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
        #1;
        chk_reset_vals("reset_mid");
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk_init("reinit", 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
